lcd_spi_arbiter: RTL and testbench

LCD_SPI_ARBITER -- requirements
Module: lcd_spi_arbiter

---
 rtl/lcd_spi_arbiter.sv | 158 +++++++++++++++
 tb/tb_lcd_spi_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_arbiter.sv
// Round-robin arbiter that lends one shared SPI master to three LCD byte-burst requesters.
// A granted requester keeps ownership until its burst ends, it releases early, or the link stalls.
module lcd_spi_arbiter #(
  parameter logic [31:0] TIMEOUT = 32'd400000000,
  parameter int          TO_W    = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_req,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_data1,
  input  logic [7:0] i_data2,
  input  logic [2:0] i_dc,
  input  logic [2:0] i_last,
  output logic [2:0] o_grant,
  output logic [2:0] o_ack,
  output logic       o_spi_start,
  output logic [7:0] o_spi_data,
  output logic       o_spi_dc,
  input  logic       i_spi_avail,
  input  logic       i_spi_busy,
  output logic       o_active,
  output logic       o_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 32'd1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  state_t          r_state;
  state_t          w_nextState;
  logic [2:0]      r_grant;
  logic [2:0]      w_nextGrant;
  logic [1:0]      r_ptr;
  logic [1:0]      w_nextPtr;
  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_nextCnt;
  logic            r_err;
  logic            w_nextErr;
  logic [1:0]      w_ownerIdx;
  logic [1:0]      w_ownerNext;
  logic [2:0]      w_pick;
  logic            w_ownerReq;
  logic            w_ownerLast;

  // Search ptr, ptr+1, ptr+2 (mod 3); descending loop lets the nearest candidate win.
  function automatic logic [2:0] rrPick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rrPick = 3'b000;
    for (int j = 2; j >= 0; j--) begin
      idx = 2'((int'(ptr) + j) % 3);
      if (req[idx]) begin
        rrPick = 3'b001 << idx;
      end
    end
  endfunction

  always_comb begin
    w_ownerIdx = 2'd0;
    case (r_grant)
      3'b010:  w_ownerIdx = 2'd1;
      3'b100:  w_ownerIdx = 2'd2;
      default: w_ownerIdx = 2'd0;
    endcase
  end

  assign w_pick      = rrPick(i_req, r_ptr);
  assign w_ownerReq  = i_req[w_ownerIdx];
  assign w_ownerLast = i_last[w_ownerIdx];
  assign w_ownerNext = (w_ownerIdx == 2'd2) ? 2'd0 : w_ownerIdx + 2'd1;

  always_comb begin
    o_spi_start = 1'b0;
    o_spi_data  = 8'h00;
    o_spi_dc    = 1'b0;
    o_ack       = 3'b000;
    if (r_state == S_XFER) begin
      o_spi_start = 1'b1;
      o_spi_dc    = i_dc[w_ownerIdx];
      o_ack       = r_grant & {3{i_spi_avail}};
      case (w_ownerIdx)
        2'd1:    o_spi_data = i_data1;
        2'd2:    o_spi_data = i_data2;
        default: o_spi_data = i_data0;
      endcase
    end
  end

  // A byte accepted in the same cycle the owner drops req is still acked before releasing.
  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_nextPtr   = r_ptr;
    w_nextCnt   = r_cnt;
    w_nextErr   = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_req != 3'b000) begin
          w_nextGrant = w_pick;
          w_nextCnt   = '0;
          w_nextState = S_XFER;
        end
      end
      S_XFER: begin
        if (i_spi_avail) begin
          w_nextCnt = '0;
          if (w_ownerLast || !w_ownerReq) begin
            w_nextState = S_DRAIN;
          end
        end else if (!w_ownerReq) begin
          w_nextState = S_DRAIN;
        end else if (r_cnt == TO_LAST) begin
          w_nextErr   = 1'b1;
          w_nextState = S_DRAIN;
        end else begin
          w_nextCnt = r_cnt + TO_ONE;
        end
      end
      S_DRAIN: begin
        if (!i_spi_busy) begin
          w_nextGrant = 3'b000;
          w_nextPtr   = w_ownerNext;
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextGrant = 3'b000;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 3'b000;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_grant <= w_nextGrant;
      r_ptr   <= w_nextPtr;
      r_cnt   <= w_nextCnt;
      r_err   <= w_nextErr;
    end
  end

  assign o_grant  = r_grant;
  assign o_active = (r_state != S_IDLE);
  assign o_err    = r_err;

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Randomized scoreboard bench for lcd_spi_arbiter: requester and SPI-master models drive the DUT,
// a transaction-level round-robin model predicts which bytes must be acked, in which order.
module tb_lcd_spi_arbiter;

  typedef struct {
    int         owner;
    logic [7:0] data;
    logic       dc;
  } expItem_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] req;
  logic [7:0] data0, data1, data2;
  logic [2:0] dc;
  logic [2:0] last;
  logic [2:0] grant;
  logic [2:0] ack;
  logic       spiStart;
  logic [7:0] spiData;
  logic       spiDc;
  logic       spiAvail;
  logic       spiBusy;
  logic       active;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  expItem_t   sb[$];
  logic [7:0] burstData [3][8];
  logic       burstDc   [3][8];
  int         burstLen  [3];
  int         burstDrop [3];
  int         burstIdx  [3];
  logic [2:0] reqActive;
  int         ptrModel;

  bit         spiAuto;
  logic       manAvail, manBusy;
  int         spiCnt, spiTarget, spiBusyLeft;

  always #5 clk = ~clk;

  lcd_spi_arbiter #(.TIMEOUT(32'd16), .TO_W(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_req      (req),
    .i_data0    (data0),
    .i_data1    (data1),
    .i_data2    (data2),
    .i_dc       (dc),
    .i_last     (last),
    .o_grant    (grant),
    .o_ack      (ack),
    .o_spi_start(spiStart),
    .o_spi_data (spiData),
    .o_spi_dc   (spiDc),
    .i_spi_avail(spiAvail),
    .i_spi_busy (spiBusy),
    .o_active   (active),
    .o_err      (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Requester k presents byte burstIdx[k] of its burst and holds req until finished or released.
  function automatic void driveInputs();
    logic [7:0] b;
    req = reqActive;
    for (int k = 0; k < 3; k++) begin
      b     = (burstIdx[k] < 8) ? burstData[k][burstIdx[k]] : 8'h00;
      dc[k] = (burstIdx[k] < 8) ? burstDc[k][burstIdx[k]] : 1'b0;
      last[k] = (burstIdx[k] == burstLen[k] - 1);
      case (k)
        0:       data0 = b;
        1:       data1 = b;
        default: data2 = b;
      endcase
    end
  endfunction

  // One clock: sample outputs mid-cycle, advance requester and SPI models, drive just after the edge.
  task automatic applyStimulus();
    logic [2:0] sAck;
    logic       sStart;
    logic       nextAvail;
    logic       nextBusy;
    @(negedge clk);
    sAck   = ack;
    sStart = spiStart;
    for (int k = 0; k < 3; k++) begin
      if (reqActive[k] && sAck[k]) begin
        burstIdx[k]++;
        if (burstIdx[k] >= burstLen[k] || burstIdx[k] >= burstDrop[k]) reqActive[k] = 1'b0;
      end
    end
    if (spiAuto) begin
      nextAvail = 1'b0;
      if (spiAvail) begin
        spiCnt      = 0;
        spiTarget   = $urandom_range(1, 5);
        spiBusyLeft = $urandom_range(0, 5);
      end else if (sStart) begin
        spiCnt++;
        nextAvail = (spiCnt >= spiTarget);
      end else begin
        spiCnt = 0;
        if (spiBusyLeft > 0) spiBusyLeft--;
      end
      nextBusy = sStart || (spiBusyLeft > 0);
    end else begin
      nextAvail = manAvail;
      nextBusy  = manBusy;
    end
    @(posedge clk);
    #1;
    spiAvail = nextAvail;
    spiBusy  = nextBusy;
    driveInputs();
  endtask

  task automatic prepBurst(input int k, input int len, input int drop);
    burstLen[k]  = len;
    burstDrop[k] = drop;
    burstIdx[k]  = 0;
    for (int i = 0; i < 8; i++) begin
      burstData[k][i] = 8'($urandom);
      burstDc[k][i]   = 1'($urandom);
    end
  endtask

  // Reference: owners served in circular order from ptr; each yields min(len, drop) acked bytes.
  task automatic runPhase(input logic [2:0] mask);
    int order[$];
    int waited;
    for (int j = 0; j < 3; j++) begin
      if (mask[(ptrModel + j) % 3]) order.push_back((ptrModel + j) % 3);
    end
    foreach (order[j]) begin
      int k;
      int n;
      k = order[j];
      n = (burstDrop[k] < burstLen[k]) ? burstDrop[k] : burstLen[k];
      for (int i = 0; i < n; i++) begin
        expItem_t e;
        e.owner = k;
        e.data  = burstData[k][i];
        e.dc    = burstDc[k][i];
        sb.push_back(e);
      end
    end
    ptrModel  = (order[order.size() - 1] + 1) % 3;
    reqActive = mask;
    applyStimulus();
    applyStimulus();
    checkOutput("first_grant", 32'(grant), 32'(1) << order[0]);
    waited = 0;
    while ((reqActive != 3'b000 || active) && waited < 2000) begin
      applyStimulus();
      waited++;
    end
    checkOutput("phase_done", 32'(waited >= 2000), 32'(0));
    checkOutput("sb_drained", 32'(sb.size()), 32'(0));
  endtask

  always @(negedge clk) begin : monitor
    expItem_t e;
    logic [2:0] prevGrant;
    if (ack != 3'b000) begin
      if (sb.size() == 0) begin
        checkOutput("ack_unexpected", 32'(ack), 32'(0));
      end else begin
        e = sb.pop_front();
        checkOutput("ack_owner", 32'(ack), 32'(1) << e.owner);
        checkOutput("ack_grant", 32'(grant), 32'(1) << e.owner);
        checkOutput("spi_data", 32'(spiData), 32'(e.data));
        checkOutput("spi_dc", 32'(spiDc), 32'(e.dc));
      end
    end
    if (!spiStart) checkOutput("idle_outputs", 32'({ack, spiData, spiDc}), 32'(0));
    if (prevGrant !== 3'b000 && prevGrant !== 3'bxxx && grant != prevGrant)
      checkOutput("grant_hold", 32'(grant), 32'(0));
    prevGrant = grant;
  end

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int xc;
    int held;
    int len;
    int drop;
    logic [2:0] mask;
    expItem_t e;

    for (int k = 0; k < 3; k++) prepBurst(k, 0, 99);
    reqActive = 3'b000;
    ptrModel  = 0;
    spiAuto   = 1'b1;
    manAvail  = 1'b0;
    manBusy   = 1'b0;
    spiCnt = 0; spiTarget = 1; spiBusyLeft = 0;
    rstN = 1'b0;
    driveInputs();
    req      = 3'b111;
    spiAvail = 1'b1;
    spiBusy  = 1'b0;
    #12;
    checkOutput("rst_grant", 32'(grant), 32'(0));
    checkOutput("rst_ack", 32'(ack), 32'(0));
    checkOutput("rst_start", 32'(spiStart), 32'(0));
    checkOutput("rst_active", 32'(active), 32'(0));
    checkOutput("rst_err", 32'(err), 32'(0));
    spiAvail = 1'b0;
    driveInputs();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus();
    checkOutput("idle_no_req", 32'(grant), 32'(0));

    $display("[TB] contention from reset");
    for (int k = 0; k < 3; k++) prepBurst(k, 4, 99);
    runPhase(3'b111);

    $display("[TB] single init burst");
    prepBurst(0, 4, 99);
    burstData[0][0] = 8'h21; burstData[0][1] = 8'h90;
    burstData[0][2] = 8'h20; burstData[0][3] = 8'h0C;
    for (int i = 0; i < 4; i++) burstDc[0][i] = 1'b0;
    runPhase(3'b001);

    prepBurst(1, 1, 99);
    runPhase(3'b010);

    $display("[TB] early release");
    prepBurst(2, 5, 2);
    prepBurst(0, $urandom_range(1, 6), 99);
    prepBurst(1, $urandom_range(1, 6), 99);
    runPhase(3'b111);

    $display("[TB] random phases");
    for (int p = 0; p < 30; p++) begin
      mask = 3'($urandom_range(1, 7));
      for (int k = 0; k < 3; k++) begin
        len  = $urandom_range(1, 6);
        drop = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 99;
        prepBurst(k, len, drop);
      end
      runPhase(mask);
    end
    checkOutput("err_clear", 32'(err), 32'(0));

    $display("[TB] timeout");
    spiAuto = 1'b0;
    manAvail = 1'b0;
    manBusy  = 1'b1;
    prepBurst(1, 3, 99);
    reqActive = 3'b010;
    applyStimulus();
    applyStimulus();
    checkOutput("to_grant", 32'(grant), 32'(3'b010));
    xc = 0;
    while (spiStart && xc < 100) begin
      xc++;
      applyStimulus();
    end
    checkOutput("to_cycles", 32'(xc), 32'(16));
    checkOutput("to_err", 32'(err), 32'(1));
    reqActive = 3'b000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("to_hold", 32'(grant), 32'(3'b010));
    end
    manBusy = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("to_release", 32'(grant), 32'(0));
    checkOutput("to_err_sticky", 32'(err), 32'(1));
    ptrModel = 2;

    $display("[TB] drain wait");
    prepBurst(0, 2, 99);
    for (int i = 0; i < 2; i++) begin
      e.owner = 0;
      e.data  = burstData[0][i];
      e.dc    = burstDc[0][i];
      sb.push_back(e);
    end
    reqActive = 3'b001;
    applyStimulus();
    applyStimulus();
    checkOutput("dr_grant", 32'(grant), 32'(3'b001));
    manAvail = 1'b1;
    applyStimulus();
    manAvail = 1'b0;
    applyStimulus();
    applyStimulus();
    manAvail = 1'b1;
    manBusy  = 1'b1;
    applyStimulus();
    manAvail = 1'b0;
    applyStimulus();
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (grant == 3'b001 && !spiStart && active) held++;
      applyStimulus();
    end
    checkOutput("dr_hold", 32'(held), 32'(10));
    manBusy = 1'b0;
    applyStimulus();
    checkOutput("dr_still", 32'(grant), 32'(3'b001));
    applyStimulus();
    checkOutput("dr_release", 32'(grant), 32'(0));
    checkOutput("dr_sb", 32'(sb.size()), 32'(0));
    ptrModel = 1;

    $display("[TB] reset mid-burst");
    manBusy = 1'b1;
    prepBurst(2, 3, 99);
    reqActive = 3'b100;
    applyStimulus();
    applyStimulus();
    checkOutput("mr_xfer", 32'({grant, spiStart}), 32'({3'b100, 1'b1}));
    rstN = 1'b0;
    #1;
    checkOutput("mr_start", 32'(spiStart), 32'(0));
    checkOutput("mr_grant", 32'(grant), 32'(0));
    checkOutput("mr_err", 32'(err), 32'(0));
    checkOutput("mr_active", 32'(active), 32'(0));
    reqActive = 3'b000;
    manBusy   = 1'b0;
    sb.delete();
    applyStimulus();
    ptrModel = 0;
    spiAuto  = 1'b1;
    spiCnt = 0; spiBusyLeft = 0;
    rstN = 1'b1;
    prepBurst(0, $urandom_range(1, 6), 99);
    prepBurst(2, $urandom_range(1, 6), 99);
    runPhase(3'b101);
    prepBurst(2, $urandom_range(1, 6), 99);
    runPhase(3'b100);

    for (int p = 0; p < 5; p++) begin
      mask = 3'($urandom_range(1, 7));
      for (int k = 0; k < 3; k++) prepBurst(k, $urandom_range(1, 6), 99);
      runPhase(mask);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
